// File: rtl/ram_seq_ctrl.sv
// Request/response sequencer for an asynchronous 8-bit RAM.
// All RAM-side lines come straight from flops so setup/strobe/hold edges stay glitch-free.
module ram_seq_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_on,
    input  logic [DATA_W-1:0] ram_data_out
);

    // Handshake: a request transfers on the rising edge where req_valid && req_ready;
    // req_ready is high only while idle, and the response is a single-cycle rsp_valid
    // pulse that the consumer cannot stall.

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SETUP,
        S_WR_STROBE,
        S_WR_HOLD,
        S_RESP
    } state_t;

    localparam logic [1:0]        OP_READ  = 2'b00;
    localparam logic [1:0]        OP_WRITE = 2'b01;
    localparam logic [1:0]        OP_FILL  = 2'b10;
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                rd_wait_q, rd_wait_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic [ADDR_W:0]     fill_end;
    logic                addr_oob;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        rd_wait_d  = rd_wait_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        fill_end   = {1'b0, req_addr} + {1'b0, req_len};
        addr_oob   = {1'b0, req_addr} >= DEPTH_X;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    data_d     = req_data;
                    rsp_data_d = req_data;
                    rsp_err_d  = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_RESP;
                    if (req_op == OP_READ && !addr_oob) begin
                        rd_wait_d = 1'b1;
                        state_d   = S_RD;
                    end else if (req_op == OP_WRITE && !addr_oob) begin
                        state_d = S_WR_SETUP;
                    end else if (req_op == OP_FILL && fill_end <= DEPTH_X) begin
                        // A zero-length fill completes without touching the RAM.
                        if (req_len != '0) begin
                            cnt_d   = req_len - ADDR_W'(1);
                            state_d = S_WR_SETUP;
                        end
                    end else begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                    end
                end
            end
            S_RD: begin
                // First RD cycle lets the RAM settle on the new address; sample on the second.
                if (rd_wait_q) begin
                    rd_wait_d = 1'b0;
                end else begin
                    rsp_data_d = ram_data_out;
                    state_d    = S_RESP;
                end
            end
            S_WR_SETUP:  state_d = S_WR_STROBE;
            S_WR_STROBE: state_d = S_WR_HOLD;
            S_WR_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q - ADDR_W'(1);
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_WR_SETUP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        we_d = (state_d == S_WR_STROBE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            rd_wait_q  <= 1'b0;
            we_q       <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            rd_wait_q  <= rd_wait_d;
            we_q       <= we_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign rsp_valid    = (state_q == S_RESP);
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;
    assign ram_address  = addr_q;
    assign ram_data_in  = data_q;
    assign ram_write_on = we_q;

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Directed bench for ram_seq_ctrl: a RAM model, a cycle-offset behavioural model of each
// request, a per-cycle compare process and literal expectations for the test-plan cases.
module tb_ram_seq_ctrl;
    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid, req_ready, rsp_valid, rsp_err, ram_write_on;
    logic [1:0]    req_op;
    logic [AW-1:0] req_addr, req_len, ram_address;
    logic [DW-1:0] req_data, rsp_data, ram_data_in, ram_data_out;

    ram_seq_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_len(req_len), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_write_on(ram_write_on), .ram_data_out(ram_data_out)
    );

    // ---------------- RAM model ----------------
    function automatic logic [7:0] init_val(input int a);
        return 8'((a * 7 + 1) & 255);
    endfunction

    logic [DW-1:0] ram [256];
    logic [255:0]  ram_wv = '0;
    always @(posedge clk)
        if (ram_write_on) begin
            ram[ram_address]    <= ram_data_in;
            ram_wv[ram_address] <= 1'b1;
        end
    assign ram_data_out = ram_wv[ram_address] ? ram[ram_address] : init_val(int'(ram_address));

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    int          k = -1;           // cycles since accept edge, -1 when idle
    int          lat, nwr;
    logic [7:0]  cur_addr, cur_data, cur_exp_data;
    logic        cur_exp_err, cur_is_rd;
    bit          chk_en = 1'b0;
    logic [8:0]  exp_q[$];
    logic [7:0]  exp_mem [256];
    int          n_strobe = 0;
    logic [7:0]  strobe_log[$];
    logic [7:0]  last_rsp_data;
    logic        last_rsp_err;

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [8:0] e;
        if (ram_write_on) begin
            n_strobe++;
            strobe_log.push_back(ram_address);
        end
        if (rsp_valid) begin
            last_rsp_data = rsp_data;
            last_rsp_err  = rsp_err;
        end
        if (chk_en) begin
            if (k < 0) begin
                check("idle_ready", req_ready, 1);
                check("idle_rsp_valid", rsp_valid, 0);
                check("idle_write_on", ram_write_on, 0);
            end else begin
                if (k == 0) exp_q.push_back({cur_exp_err, cur_exp_data});
                check("req_ready", req_ready, k > lat);
                check("rsp_valid", rsp_valid, k == lat);
                if (k == lat) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_expected", 0, 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_data", rsp_data, e[7:0]);
                        check("rsp_err", rsp_err, e[8]);
                    end
                end
                check("ram_write_on", ram_write_on, (k < 3 * nwr) && (k % 3 == 1));
                if (k < 3 * nwr) begin
                    check("wr_address", ram_address, 8'(cur_addr + k / 3));
                    check("wr_data_in", ram_data_in, cur_data);
                end
                if (cur_is_rd && k < 2) check("rd_address", ram_address, cur_addr);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] len,
                          input logic [7:0] data, input bit hold);
        bit err;
        err = (op == 2'b11) || (op != 2'b10 && int'(addr) >= DEPTH) ||
              (op == 2'b10 && int'(addr) + int'(len) > DEPTH);
        @(negedge clk);
        #1;
        cur_addr = addr;
        cur_data = data;
        cur_exp_err = err;
        cur_is_rd = (op == 2'b00) && !err;
        if (err) begin
            lat = 0; nwr = 0; cur_exp_data = 8'h00;
        end else if (op == 2'b00) begin
            lat = 2; nwr = 0; cur_exp_data = exp_mem[addr];
        end else begin
            nwr = (op == 2'b01) ? 1 : int'(len);
            lat = 3 * nwr;
            cur_exp_data = data;
            for (int i = 0; i < nwr; i++) exp_mem[8'(addr + i)] = data;
        end
        req_op = op; req_addr = addr; req_len = len; req_data = data; req_valid = 1'b1;
        for (int c = 0; c <= lat + 1; c++) begin
            @(posedge clk);
            #1;
            k = c;
            if (c == (hold ? lat : 0)) req_valid = 1'b0;
        end
        @(negedge clk);
        #1;
        k = -1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int s;
        logic [7:0] rd_exp [6];
        logic [1:0] bad_op [5];
        logic [7:0] bad_addr [5];
        rd_exp = '{8'h08, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h2B};
        bad_op = '{2'b11, 2'b00, 2'b01, 2'b00, 2'b01};
        bad_addr = '{8'd0, 8'd11, 8'd11, 8'd255, 8'd255};
        for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);
        req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_len = '0; req_data = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_ram_address", ram_address, 0);
        check("rst_ram_data_in", ram_data_in, 0);
        check("rst_ram_write_on", ram_write_on, 0);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;

        // single write
        s = n_strobe;
        do_req(2'b01, 8'd3, 8'd0, 8'hA5, 1'b0);
        check("wr3_strobes", n_strobe - s, 1);
        check("wr3_strobe_addr", strobe_log[s], 8'd3);
        check("wr3_rsp_data", last_rsp_data, 8'hA5);
        check("wr3_rsp_err", last_rsp_err, 0);

        // write then read
        do_req(2'b01, 8'd7, 8'd0, 8'h3C, 1'b0);
        s = n_strobe;
        do_req(2'b00, 8'd7, 8'd0, 8'h00, 1'b0);
        check("rd7_no_strobe", n_strobe - s, 0);
        check("rd7_rsp_data", last_rsp_data, 8'h3C);

        // fill 2..5
        s = n_strobe;
        do_req(2'b10, 8'd2, 8'd4, 8'h5A, 1'b0);
        check("fill_strobes", n_strobe - s, 4);
        for (int i = 0; i < 4; i++) check("fill_strobe_addr", strobe_log[s + i], 8'(2 + i));
        for (int i = 0; i < 6; i++) begin
            do_req(2'b00, 8'(1 + i), 8'd0, 8'h00, 1'b0);
            check("fill_readback", last_rsp_data, rd_exp[i]);
        end

        // boundary fills
        s = n_strobe;
        do_req(2'b10, 8'd9, 8'd3, 8'hEE, 1'b0);
        check("fill9_err", last_rsp_err, 1);
        check("fill9_data", last_rsp_data, 8'h00);
        check("fill9_no_strobe", n_strobe - s, 0);
        do_req(2'b00, 8'd9, 8'd0, 8'h00, 1'b0);
        check("fill9_ram_unchanged", last_rsp_data, 8'h40);
        s = n_strobe;
        do_req(2'b10, 8'd8, 8'd3, 8'hC3, 1'b0);
        check("fill8_err", last_rsp_err, 0);
        check("fill8_strobes", n_strobe - s, 3);
        check("fill8_last_addr", strobe_log[s + 2], 8'd10);
        do_req(2'b00, 8'd10, 8'd0, 8'h00, 1'b0);
        check("fill8_read10", last_rsp_data, 8'hC3);
        s = n_strobe;
        do_req(2'b10, 8'd5, 8'd0, 8'h11, 1'b0);
        check("fill0_err", last_rsp_err, 0);
        check("fill0_data", last_rsp_data, 8'h11);
        check("fill0_no_strobe", n_strobe - s, 0);

        // invalid requests, some with req_valid held through the busy period
        for (int i = 0; i < 5; i++) begin
            s = n_strobe;
            do_req(bad_op[i], bad_addr[i], 8'd0, 8'h99, i[0]);
            check("bad_err", last_rsp_err, 1);
            check("bad_data", last_rsp_data, 8'h00);
            check("bad_no_strobe", n_strobe - s, 0);
        end
        s = n_strobe;
        do_req(2'b01, 8'd4, 8'd0, 8'h99, 1'b1);
        check("hold_wr_strobes", n_strobe - s, 1);
        do_req(2'b00, 8'd4, 8'd0, 8'h00, 1'b1);
        check("hold_rd_data", last_rsp_data, 8'h99);

        // reset during the second word's strobe of a 5-word fill at 0
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        req_op = 2'b10; req_addr = 8'd0; req_len = 8'd5; req_data = 8'h77; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("mid_strobe2_high", ram_write_on, 1);
        check("mid_strobe2_addr", ram_address, 8'd1);
        rst_n = 1'b0;
        #1;
        check("mid_async_drop", ram_write_on, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_ready_after", req_ready, 1);
        check("mid_no_rsp", rsp_valid, 0);
        check("mid_word0_written", ram[0], 8'h77);
        for (int i = 2; i < 5; i++) check("mid_word_unchanged", ram[i], exp_mem[i]);
        exp_mem[0] = 8'h77;
        exp_mem[1] = ram_wv[1] ? ram[1] : init_val(1);
        #1;
        chk_en = 1'b1;
        do_req(2'b00, 8'd0, 8'd0, 8'h00, 1'b0);
        check("mid_read0", last_rsp_data, 8'h77);
        do_req(2'b00, 8'd3, 8'd0, 8'h00, 1'b0);
        check("mid_read3", last_rsp_data, 8'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
